// File: rtl/imager_rx.sv
// Imager capture front-end: parses the 16-byte geometry header, packs R,G,B bytes
// into tagged pixels and queues them in a small FIFO for the downstream pipeline.
module imager_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 16
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          hd,
  input  logic          vd,
  input  logic          pxq,
  input  logic [7:0]    din,
  input  logic          enable,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [23:0]   rgb_out,
  output logic [CW-1:0] x_out,
  output logic [CW-1:0] y_out,
  output logic          sof,
  output logic          eol,
  output logic          eof,
  output logic [31:0]   width,
  output logic [31:0]   height,
  output logic          frame_done,
  output logic          overflow,
  output logic          sync_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 24 + 2 * CW + 3;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PIX} state_t;

  state_t        state_q;
  logic [3:0]    hcnt_q;
  logic [119:0]  hdr_q;
  logic [31:0]   width_q, height_q;
  logic [1:0]    ph_q;
  logic [31:0]   col_q, row_q;
  logic          first_q, resync_q;
  logic [7:0]    r_q, g_q;
  logic          frame_done_q, overflow_q, sync_err_q;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic [31:0]   x_low, x_high, y_low, y_high, width_d, height_d;
  logic          last_col, last_row, pix_fire, pop, full, push, drop, hd_expected;
  logic [EW-1:0] push_word;

  // Header bytes shift in from the top, so byte 0 lands in the low byte after 15 shifts.
  assign x_low    = hdr_q[31:0];
  assign x_high   = hdr_q[63:32];
  assign y_low    = hdr_q[95:64];
  assign y_high   = {din, hdr_q[119:96]};
  assign width_d  = x_high - x_low;
  assign height_d = y_high - y_low;

  assign last_col    = (col_q == width_q - 32'd1);
  assign last_row    = (row_q == height_q - 32'd1);
  assign hd_expected = (ph_q == 2'd0) && (col_q == 32'd0);
  assign pix_fire    = (state_q == S_PIX) && pxq && !first_q && !resync_q &&
                       !vd && !hd && (ph_q == 2'd2);

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push      = pix_fire && (!full || pop);
  assign drop      = pix_fire && full && !pop;
  assign push_word = {r_q, g_q, din, col_q[CW-1:0], row_q[CW-1:0],
                      (col_q == 32'd0) && (row_q == 32'd0), last_col, last_col && last_row};

  assign {rgb_out, x_out, y_out, sof, eol, eof} = mem_q[rd_ptr_q];
  assign width      = width_q;
  assign height     = height_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign sync_err   = sync_err_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hcnt_q       <= '0;
      hdr_q        <= '0;
      width_q      <= '0;
      height_q     <= '0;
      ph_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      first_q      <= 1'b0;
      resync_q     <= 1'b0;
      r_q          <= '0;
      g_q          <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (drop) overflow_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (pxq) begin
            if (vd || hd) begin
              sync_err_q <= 1'b1;
            end else if (enable) begin
              hdr_q      <= {din, hdr_q[119:8]};
              hcnt_q     <= 4'd1;
              state_q    <= S_HDR;
              sync_err_q <= 1'b0;
              overflow_q <= 1'b0;
            end
          end
        end
        S_HDR: begin
          if (pxq) begin
            if (vd || hd) begin
              sync_err_q <= 1'b1;
              state_q    <= S_IDLE;
            end else if (hcnt_q == 4'd15) begin
              width_q  <= width_d;
              height_q <= height_d;
              ph_q     <= '0;
              col_q    <= '0;
              row_q    <= '0;
              first_q  <= 1'b1;
              resync_q <= 1'b0;
              if (width_d == 32'd0 || height_d == 32'd0) begin
                sync_err_q <= 1'b1;
                state_q    <= S_IDLE;
              end else begin
                state_q <= S_PIX;
              end
            end else begin
              hdr_q  <= {din, hdr_q[119:8]};
              hcnt_q <= hcnt_q + 4'd1;
            end
          end
        end
        S_PIX: begin
          if (pxq) begin
            if (first_q ? !(vd && hd) : vd) begin
              sync_err_q <= 1'b1;
              state_q    <= S_IDLE;
            end else if (first_q) begin
              r_q     <= din;
              ph_q    <= 2'd1;
              first_q <= 1'b0;
            end else if (resync_q) begin
              // Bytes are dropped until the imager marks a line start; row is kept.
              if (hd) begin
                r_q      <= din;
                ph_q     <= 2'd1;
                col_q    <= '0;
                resync_q <= 1'b0;
              end
            end else if (hd != hd_expected) begin
              sync_err_q <= 1'b1;
              col_q      <= '0;
              if (hd) begin
                r_q  <= din;
                ph_q <= 2'd1;
              end else begin
                ph_q     <= 2'd0;
                resync_q <= 1'b1;
              end
            end else begin
              case (ph_q)
                2'd0: begin
                  r_q  <= din;
                  ph_q <= 2'd1;
                end
                2'd1: begin
                  g_q  <= din;
                  ph_q <= 2'd2;
                end
                default: begin
                  ph_q <= 2'd0;
                  if (last_col) begin
                    col_q <= '0;
                    if (last_row) begin
                      frame_done_q <= 1'b1;
                      state_q      <= S_IDLE;
                    end else begin
                      row_q <= row_q + 32'd1;
                    end
                  end else begin
                    col_q <= col_q + 32'd1;
                  end
                end
              endcase
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/imager_rx.md
Name: imager_rx

Overview:
- Capture front-end directly downstream of the imager model.
- Parses the 16-byte geometry header, then packs the R,G,B byte stream into 24-bit pixels tagged with x/y coordinates and frame/line flags.
- Pixels pass through a small FIFO to the colour-conversion/JPEG pipeline over a valid/ready handshake.
- Imager has no backpressure, so overflow and sync faults are flagged, never stalled.

Parameters:
FIFO_DEPTH, 4, pixel FIFO entries (power of 2, >=2)
CW, 16, width of coordinate outputs x_out/y_out

Ports:
clk_in  in  1  clock, same domain as imager
rst_n  in  1  asynchronous active-low reset
hd  in  1  line sync from imager, high on first byte of each line
vd  in  1  frame sync from imager, high on first data byte of frame
pxq  in  1  byte qualifier; din valid when high
din  in  8  imager byte stream
enable  in  1  arm capture; sampled only in IDLE
out_valid  out  1  pixel available
out_ready  in  1  consumer accepts pixel when high with out_valid
rgb_out  out  24  {R,G,B} pixel
x_out  out  CW  column, 0-based
y_out  out  CW  row, 0-based
sof  out  1  pixel is (0,0)
eol  out  1  pixel is last in its row
eof  out  1  pixel is last of frame
width  out  32  x_high - x_low, valid once header complete
height  out  32  y_high - y_low, valid once header complete
frame_done  out  1  one-cycle pulse when eof pixel is written to FIFO
overflow  out  1  sticky: pixel dropped, FIFO full
sync_err  out  1  sticky: framing violation

Behaviour:
- Reset (rst_n low, any time, including mid-frame): state IDLE; FIFO empty; all counters zero; out_valid, frame_done, overflow, sync_err, width, height = 0. rgb_out/x_out/y_out/flags = 0.
- Sticky flags clear only on reset, or on IDLE->HDR entry.
- States:
  - IDLE: if enable && pxq && !vd && !hd, the byte is header byte 0; go HDR with hcnt=1. A pxq byte with vd or hd high in IDLE sets sync_err and is ignored.
  - HDR: each pxq byte is stored at hcnt, little-endian.
    - Bytes 0-3 x_low, 4-7 x_high, 8-11 y_low, 12-15 y_high.
    - After byte 15: width/height registered (32-bit modulo subtraction); go PIX next cycle.
    - vd or hd high during HDR: sync_err, return to IDLE.
  - PIX: byte phase ph 0,1,2 = R,G,B; col, row counters.
    - First byte must have vd=1 && hd=1; else sync_err and go IDLE.
    - hd must be 1 exactly when ph==0 && col==0; mismatch sets sync_err, discards the partial pixel, and resyncs at the next hd byte (row held).
    - vd high other than first byte: sync_err, go IDLE.
    - On ph==2: push {R,G,B,col,row,sof,eol,eof}; ph=0; col++, wrapping to 0 with row++ at col==width-1.
    - On eof push: frame_done pulse same cycle; go IDLE.
    - width==0 or height==0 at header end: sync_err, go IDLE.
- Pixel latency: the pixel appears on out_valid the cycle after its B byte is clocked (registered FIFO head).
- FIFO:
  - Push on B byte; pop on out_valid && out_ready. Simultaneous push/pop when full is allowed (no drop).
  - Push when full without pop: pixel dropped, overflow set, counters still advance so coordinates stay correct.
  - out_valid = FIFO not empty. Outputs hold stable while out_valid && !out_ready.
- pxq low cycles are idle; state and counters hold. Gaps between bytes are permitted.
- enable deassert outside IDLE has no effect until frame end.

Test Plan:
- 2x2 frame: header 00 00 00 00 02 00 00 00 00 00 00 00 02 00 00 00, then 12 bytes 11 22 33 44 55 66 77 88 99 AA BB CC with vd on byte 0 and hd on bytes 0 and 6; out_ready=1 -> width=2, height=2. Pixels 112233 (0,0,sof), 445566 (1,0,eol), 778899 (0,1), AABBCC (1,1,eol,eof). frame_done pulses once.
- Same frame with out_ready=0 throughout, FIFO_DEPTH=4 -> 4 pixels held, no overflow. A second frame's first pixel sets overflow; out_valid stays 1 with rgb_out=112233.
- hd withheld on byte 6 of the 2x2 frame -> sync_err=1. Partial pixel discarded; capture resyncs on the next hd byte.
- rst_n pulsed low mid-PIX (after byte 4) -> out_valid=0 immediately. State IDLE; the next valid header parses correctly.
- x_low=10, x_high=13, y_low=5, y_high=6 -> width=3, height=1. Three pixels at x 0..2, y 0; the last carries eol and eof.
- pxq gaps of 3 cycles between every byte -> identical pixel output as the gapless case.
